ifu_fetch: RTL and testbench

- Instruction fetch stage feeding the IF/ID register of the 5-stage core.
- Holds the architectural fetch PC and issues in-order requests to the instruction memory port.
- Buffers returned instructions with their PCs.
- Redirects on the branch unit's take_branch/target_pc from EX, discarding wrong-path requests already in flight.

---
 rtl/ifu_fetch_pkg.sv | 20 ++
 rtl/ifu_fetch_if.sv | 24 ++
 rtl/ifu_fifo.sv | 59 +++++
 rtl/ifu_fetch.sv | 95 +++++++++
 tb/tb_ifu_fetch.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared types and PC helpers for the instruction fetch stage
package ifu_fetch_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - redirect, imem and IF/ID handshake bundle of the fetch stage
interface ifu_fetch_if;
   logic        ex_take_branch;
   logic [31:0] ex_target_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;

   modport master (
      input  ex_take_branch, ex_target_pc, imem_ready, imem_rvalid, imem_rdata, if_ready,
      output imem_req, imem_addr, if_valid, if_pc, if_instr
   );

   modport slave (
      output ex_take_branch, ex_target_pc, imem_ready, imem_rvalid, imem_rdata, if_ready,
      input  imem_req, imem_addr, if_valid, if_pc, if_instr
   );
endinterface

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous FIFO with flush; push is accepted when full if a pop happens
module ifu_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch PC, credit-limited imem requests, wrong-path drop counter
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input logic          clk,
   input logic          rst,
   ifu_fetch_if.master  bus
);
   localparam int             CNT_W   = $clog2(DEPTH+1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

   logic [31:0]      fetch_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] drop_nxt;
   logic [CNT_W:0]   inflight;
   logic [31:0]      pend_pc;
   logic             pend_full;
   logic             pend_empty;
   logic             out_full;
   logic             out_empty;
   logic             accept;
   logic             buf_push;
   logic             buf_pop;
   fetch_entry_t     head;
   fetch_entry_t     resp;

   assign inflight     = {1'b0, outstanding} + {1'b0, occupancy};
   assign bus.imem_req = !rst && !bus.ex_take_branch && !pend_full && (inflight < DEPTH_C);
   assign bus.imem_addr = fetch_pc;
   assign accept       = bus.imem_req && bus.imem_ready;

   assign bus.if_valid = !out_empty && !bus.ex_take_branch;
   assign bus.if_pc    = head.pc;
   assign bus.if_instr = head.instr;
   assign buf_pop      = bus.if_valid && bus.if_ready;
   assign buf_push     = bus.imem_rvalid && (drop_cnt == '0) && !bus.ex_take_branch;
   assign resp         = '{pc: pend_pc, instr: bus.imem_rdata};

   // The pending-PC queue depth doubles as the outstanding-request count.
   ifu_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (accept),
      .pop   (bus.imem_rvalid),
      .din   (fetch_pc),
      .dout  (pend_pc),
      .full  (pend_full),
      .empty (pend_empty),
      .count (outstanding)
   );

   ifu_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_obuf (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.ex_take_branch),
      .push  (buf_push),
      .pop   (buf_pop),
      .din   (resp),
      .dout  (head),
      .full  (out_full),
      .empty (out_empty),
      .count (occupancy)
   );

   // On redirect every request still in flight after this cycle's response is wrong-path.
   always_comb begin
      drop_nxt = drop_cnt;
      if (bus.ex_take_branch) begin
         drop_nxt = outstanding - (bus.imem_rvalid ? CNT_W'(1) : CNT_W'(0));
      end else if (bus.imem_rvalid && (drop_cnt != '0)) begin
         drop_nxt = drop_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_nxt;
         if (bus.ex_take_branch) fetch_pc <= word_align(bus.ex_target_pc);
         else if (accept)        fetch_pc <= pc_next(fetch_pc);
      end
   end

   a_credit: assert property (@(posedge clk) disable iff (rst) inflight <= DEPTH_C);
   a_resp:   assert property (@(posedge clk) disable iff (rst) !(bus.imem_rvalid && pend_empty));
   a_ovf:    assert property (@(posedge clk) disable iff (rst) !(buf_push && out_full && !buf_pop));
endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed bench for ifu_fetch with an in-order latency memory model
module tb_ifu_fetch;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cycle;
   int   lat;
   logic [31:0] q[$];
   int          qd[$];
   logic [31:0] got[$];

   ifu_fetch_if bus();

   ifu_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic cyc();
      logic        acc;
      logic [31:0] a;
      acc = bus.imem_req && bus.imem_ready;
      a   = bus.imem_addr;
      if (bus.if_valid && bus.if_ready) begin
         got.push_back(bus.if_pc);
         chk("deliver_instr", bus.if_instr, instr_of(bus.if_pc));
      end
      if (bus.imem_rvalid && q.size() > 0) begin
         void'(q.pop_front());
         void'(qd.pop_front());
      end
      if (acc) begin
         q.push_back(a);
         qd.push_back(cycle + lat);
      end
      @(posedge clk);
      #1;
      cycle++;
      if (q.size() > 0 && qd[0] <= cycle) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = instr_of(q[0]);
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = 32'h0;
      end
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.imem_ready = 1'b0;
      bus.if_ready   = 1'b1;
      settle();
      while ((q.size() != 0 || bus.if_valid) && n < 40) begin
         cyc();
         n++;
      end
      chk("drain_timeout", 32'(n < 40), 32'd1);
   endtask

   initial begin
      checks = 0; failures = 0; cycle = 0; lat = 1;
      rst = 1'b1;
      bus.ex_take_branch = 1'b0;
      bus.ex_target_pc   = 32'h0;
      bus.imem_ready     = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = 32'h0;
      bus.if_ready       = 1'b0;
      settle();
      chk("rst_req",    32'(bus.imem_req), 32'd0);
      chk("rst_valid",  32'(bus.if_valid), 32'd0);
      chk("rst_addr",   bus.imem_addr, 32'h0);
      chk("rst_pc",     bus.if_pc, 32'h0);
      chk("rst_instr",  bus.if_instr, 32'h0);
      cyc();
      cyc();

      // Streaming with 1-cycle memory, then an ID stall
      rst = 1'b0; bus.imem_ready = 1'b1; bus.if_ready = 1'b1; got.delete();
      settle();
      chk("s1_c0_req", 32'(bus.imem_req), 32'd1);
      chk("s1_c0_addr", bus.imem_addr, 32'h0);
      chk("s1_c0_valid", 32'(bus.if_valid), 32'd0);
      cyc();
      chk("s1_c1_req", 32'(bus.imem_req), 32'd1);
      chk("s1_c1_addr", bus.imem_addr, 32'h4);
      chk("s1_c1_valid", 32'(bus.if_valid), 32'd0);
      cyc();
      chk("s1_c2_valid", 32'(bus.if_valid), 32'd1);
      chk("s1_c2_pc", bus.if_pc, 32'h0);
      chk("s1_c2_req_nocredit", 32'(bus.imem_req), 32'd0);
      chk("s1_c2_addr", bus.imem_addr, 32'h8);
      cyc();
      bus.if_ready = 1'b0; settle();
      chk("s1_c3_pc", bus.if_pc, 32'h4);
      chk("s1_c3_req", 32'(bus.imem_req), 32'd1);
      chk("s1_c3_addr", bus.imem_addr, 32'h8);
      cyc();
      chk("s1_c4_req", 32'(bus.imem_req), 32'd0);
      chk("s1_c4_pc", bus.if_pc, 32'h4);
      cyc();
      chk("s1_c5_req_full", 32'(bus.imem_req), 32'd0);
      chk("s1_c5_valid", 32'(bus.if_valid), 32'd1);
      chk("s1_c5_pc_hold", bus.if_pc, 32'h4);
      cyc();
      bus.if_ready = 1'b1; settle();
      chk("s1_c6_req", 32'(bus.imem_req), 32'd0);
      chk("s1_c6_pc", bus.if_pc, 32'h4);
      cyc();
      chk("s1_c7_req_resume", 32'(bus.imem_req), 32'd1);
      chk("s1_c7_addr", bus.imem_addr, 32'hC);
      chk("s1_c7_pc", bus.if_pc, 32'h8);
      cyc();
      drain();
      chk("s1_count", 32'(got.size()), 32'd4);
      if (got.size() == 4) begin
         chk("s1_got0", got[0], 32'h0);
         chk("s1_got1", got[1], 32'h4);
         chk("s1_got2", got[2], 32'h8);
         chk("s1_got3", got[3], 32'hC);
      end

      // 3-cycle memory, redirect with two requests in flight
      got.delete(); lat = 3; bus.imem_ready = 1'b1; bus.if_ready = 1'b1; settle();
      chk("s3_a0_addr", bus.imem_addr, 32'h10);
      chk("s3_a0_req", 32'(bus.imem_req), 32'd1);
      cyc();
      chk("s3_a1_addr", bus.imem_addr, 32'h14);
      chk("s3_a1_req", 32'(bus.imem_req), 32'd1);
      cyc();
      bus.ex_take_branch = 1'b1; bus.ex_target_pc = 32'h100; settle();
      chk("s3_r_req", 32'(bus.imem_req), 32'd0);
      chk("s3_r_valid", 32'(bus.if_valid), 32'd0);
      cyc();
      bus.ex_take_branch = 1'b0; settle();
      chk("s3_r1_addr", bus.imem_addr, 32'h100);
      chk("s3_r1_req", 32'(bus.imem_req), 32'd0);
      chk("s3_r1_drop", 32'(dut.drop_cnt), 32'd2);
      cyc();
      chk("s3_r2_req", 32'(bus.imem_req), 32'd1);
      chk("s3_r2_addr", bus.imem_addr, 32'h100);
      cyc();
      chk("s3_r3_addr", bus.imem_addr, 32'h104);
      cyc();
      drain();
      chk("s3_count", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         chk("s3_got0", got[0], 32'h100);
         chk("s3_got1", got[1], 32'h104);
      end
      chk("s3_drop_end", 32'(dut.drop_cnt), 32'd0);

      // Redirect coinciding with a response and a consuming ID stage
      got.delete(); lat = 1; bus.imem_ready = 1'b1; bus.if_ready = 1'b1;
      bus.ex_take_branch = 1'b1; bus.ex_target_pc = 32'h40; settle();
      chk("s4_c0_req", 32'(bus.imem_req), 32'd0);
      cyc();
      bus.ex_take_branch = 1'b0; settle();
      chk("s4_c1_addr", bus.imem_addr, 32'h40);
      cyc();
      chk("s4_c2_addr", bus.imem_addr, 32'h44);
      cyc();
      bus.ex_take_branch = 1'b1; bus.ex_target_pc = 32'h80; settle();
      chk("s4_c3_valid", 32'(bus.if_valid), 32'd0);
      cyc();
      bus.ex_take_branch = 1'b0; settle();
      chk("s4_c4_valid", 32'(bus.if_valid), 32'd0);
      chk("s4_c4_addr", bus.imem_addr, 32'h80);
      chk("s4_c4_req", 32'(bus.imem_req), 32'd1);
      chk("s4_c4_drop", 32'(dut.drop_cnt), 32'd0);
      cyc();
      cyc();
      drain();
      chk("s4_count", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         chk("s4_got0", got[0], 32'h80);
         chk("s4_got1", got[1], 32'h84);
      end

      // Back-to-back redirects, misaligned target
      got.delete(); bus.imem_ready = 1'b1; bus.if_ready = 1'b1;
      bus.ex_take_branch = 1'b1; bus.ex_target_pc = 32'h200; settle();
      chk("s5_c0_req", 32'(bus.imem_req), 32'd0);
      cyc();
      bus.ex_target_pc = 32'h302; settle();
      chk("s5_c1_req", 32'(bus.imem_req), 32'd0);
      chk("s5_c1_addr", bus.imem_addr, 32'h200);
      cyc();
      bus.ex_take_branch = 1'b0; settle();
      chk("s5_c2_addr", bus.imem_addr, 32'h300);
      chk("s5_c2_req", 32'(bus.imem_req), 32'd1);
      cyc();
      chk("s5_c3_addr", bus.imem_addr, 32'h304);
      cyc();
      drain();
      chk("s5_count", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         chk("s5_got0", got[0], 32'h300);
         chk("s5_got1", got[1], 32'h304);
      end

      // Asynchronous reset with the output buffer full
      got.delete(); lat = 3; bus.imem_ready = 1'b1; bus.if_ready = 1'b0; settle();
      for (int i = 0; i < 6; i++) cyc();
      chk("s6_full_req", 32'(bus.imem_req), 32'd0);
      chk("s6_full_pc", bus.if_pc, 32'h308);
      #2;
      rst = 1'b1;
      #1;
      chk("s6_rst_req", 32'(bus.imem_req), 32'd0);
      chk("s6_rst_valid", 32'(bus.if_valid), 32'd0);
      chk("s6_rst_addr", bus.imem_addr, 32'h0);
      chk("s6_rst_pc", bus.if_pc, 32'h0);
      chk("s6_rst_instr", bus.if_instr, 32'h0);
      q.delete(); qd.delete();
      bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
      cyc();
      rst = 1'b0; lat = 1; bus.if_ready = 1'b1; settle();
      chk("s6_drop", 32'(dut.drop_cnt), 32'd0);
      chk("s6_c0_req", 32'(bus.imem_req), 32'd1);
      chk("s6_c0_addr", bus.imem_addr, 32'h0);
      cyc();
      chk("s6_c1_addr", bus.imem_addr, 32'h4);
      cyc();
      chk("s6_c2_valid", 32'(bus.if_valid), 32'd1);
      chk("s6_c2_pc", bus.if_pc, 32'h0);
      drain();
      chk("s6_count", 32'(got.size()), 32'd2);
      if (got.size() == 2) chk("s6_got0", got[0], 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
